// File: rtl/cpu_bus_master.sv
// cpu_bus_master: host-side initiator for the multiplexed 8051-style register bus.
// It turns one valid/ready register command into a sequenced pin cycle:
//   SETUP, ALE, AHOLD, STROBE, HOLD, RECOVER, then back to IDLE.
// Every output is registered.
// Ports:
//   clock, rst_n       : clock (posedge) and asynchronous active-low reset
//   cmd_valid/ready    : command handshake; ready is high only in IDLE
//   cmd_write          : 1 = write, 0 = read
//   cmd_addr           : 16-bit register address
//   cmd_wdata          : 8-bit write data
//   rsp_valid          : one-cycle completion pulse
//   rsp_rdata          : read data (0x00 after a write completion)
//   cs_n, ale          : chip select (active low) and address latch enable
//   abus               : high address byte
//   dbus_out, dbus_oe  : multiplexed low-address/data byte and its output enable
//   dbus_in            : sampled dbus
//   w_n, r_n           : write and read strobes (active low)
module cpu_bus_master #(
  parameter int unsigned ALE_CYC  = 2,
  parameter int unsigned STB_CYC  = 3,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned IDLE_CYC = 1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cs_n,
  output logic        ale,
  output logic [7:0]  abus,
  output logic [7:0]  dbus_out,
  output logic        dbus_oe,
  input  logic [7:0]  dbus_in,
  output logic        w_n,
  output logic        r_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ALE, S_AHOLD, S_STROBE, S_HOLD, S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len;
  logic        last;
  logic        accept;

  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;

  // Command fields as seen by the cycle being entered: on the accept edge the
  // capture registers are not yet loaded, so take the fields straight from the port.
  logic        wr;
  logic [15:0] a;
  logic [7:0]  wd;

  logic       cs_n_d, ale_d, w_n_d, r_n_d, dbus_oe_d, cmd_ready_d, rsp_valid_d;
  logic [7:0] abus_d, dbus_out_d, rsp_rdata_d;

  assign accept = cmd_valid && cmd_ready;
  assign wr     = accept ? cmd_write : write_q;
  assign a      = accept ? cmd_addr  : addr_q;
  assign wd     = accept ? cmd_wdata : wdata_q;

  always_comb begin
    len = 8'd1;
    case (state_q)
      S_ALE:     len = 8'(ALE_CYC);
      S_STROBE:  len = 8'(STB_CYC);
      S_HOLD:    len = 8'(HOLD_CYC);
      S_RECOVER: len = 8'(IDLE_CYC);
      default:   len = 8'd1;
    endcase
  end

  assign last = (cnt_q == len - 8'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_SETUP;
      end
      S_SETUP:   if (last) begin state_d = S_ALE;     cnt_d = '0; end
      S_ALE:     if (last) begin state_d = S_AHOLD;   cnt_d = '0; end
      S_AHOLD:   if (last) begin state_d = S_STROBE;  cnt_d = '0; end
      S_STROBE:  if (last) begin state_d = S_HOLD;    cnt_d = '0; end
      S_HOLD:    if (last) begin state_d = S_RECOVER; cnt_d = '0; end
      S_RECOVER: if (last) begin state_d = S_IDLE;    cnt_d = '0; end
      default:   begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

  // Pin values are decoded from the state being entered so that the registered
  // pins line up with the state register.
  always_comb begin
    cs_n_d      = 1'b1;
    ale_d       = 1'b0;
    w_n_d       = 1'b1;
    r_n_d       = 1'b1;
    dbus_oe_d   = 1'b0;
    abus_d      = abus;
    dbus_out_d  = dbus_out;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state_d)
      S_SETUP, S_ALE, S_AHOLD: begin
        cs_n_d     = 1'b0;
        ale_d      = (state_d == S_ALE);
        abus_d     = a[15:8];
        dbus_out_d = a[7:0];
        dbus_oe_d  = 1'b1;
      end
      S_STROBE, S_HOLD: begin
        cs_n_d = 1'b0;
        abus_d = a[15:8];
        if (wr) begin
          dbus_out_d = wd;
          dbus_oe_d  = 1'b1;
          w_n_d      = (state_d != S_STROBE);
        end else begin
          dbus_out_d = a[7:0];
          r_n_d      = (state_d != S_STROBE);
        end
      end
      default: ;
    endcase
    // Read data is taken on the same edge that releases r_n.
    if (state_q == S_STROBE && last) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = write_q ? 8'h00 : dbus_in;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_n      <= 1'b1;
      ale       <= 1'b0;
      w_n       <= 1'b1;
      r_n       <= 1'b1;
      dbus_oe   <= 1'b0;
      abus      <= '0;
      dbus_out  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      cs_n      <= cs_n_d;
      ale       <= ale_d;
      w_n       <= w_n_d;
      r_n       <= r_n_d;
      dbus_oe   <= dbus_oe_d;
      abus      <= abus_d;
      dbus_out  <= dbus_out_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with a responder model.
// The responder has an address latch and a w_n rising-edge detector that
// commits one clock late, and it drives read data while r_n is low.
module tb_cpu_bus_master;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cs_n, ale, dbus_oe, w_n, r_n;
  logic [7:0]  abus, dbus_out, dbus_in;
  logic [7:0]  rd_val;

  always #5 clock = ~clock;

  cpu_bus_master #(.ALE_CYC(2), .STB_CYC(3), .HOLD_CYC(2), .IDLE_CYC(1)) dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs_n(cs_n), .ale(ale), .abus(abus), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .dbus_in(dbus_in), .w_n(w_n), .r_n(r_n)
  );

  assign dbus_in = (!r_n) ? rd_val : 8'hFF;

  // Responder model and event counters
  logic [15:0] lat_addr = '0;
  logic        wn_d = 1'b1;
  logic [23:0] wr_log [$];
  int          accepts = 0;
  int          rsp_count = 0;

  always @(posedge clock) begin
    if (ale) lat_addr <= {abus, dbus_out};
    wn_d <= w_n;
    if (w_n && !wn_d && !cs_n) wr_log.push_back({lat_addr, dbus_out});
    if (rst_n && cmd_valid && cmd_ready) accepts++;
    if (rsp_valid) rsp_count++;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {cs_n, ale, w_n, r_n, dbus_oe, cmd_ready, rsp_valid} at cycle k.
  function automatic logic [6:0] exp_ctl(input int k, input logic wr);
    logic e_cs, e_ale, e_wn, e_rn, e_oe, e_rdy, e_rv;
    e_cs  = !(k >= 1 && k <= 9);
    e_ale = (k == 2 || k == 3);
    e_wn  = !(wr && k >= 5 && k <= 7);
    e_rn  = !(!wr && k >= 5 && k <= 7);
    e_oe  = (k >= 1 && k <= 4) || (wr && k >= 5 && k <= 9);
    e_rdy = (k == 11);
    e_rv  = (k == 8);
    return {e_cs, e_ale, e_wn, e_rn, e_oe, e_rdy, e_rv};
  endfunction

  task automatic run_txn(input string nm, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input bit disturb);
    int         wc0, ac0;
    logic [7:0] new_rd;
    wc0    = wr_log.size();
    ac0    = accepts;
    new_rd = wr ? 8'h00 : rd;
    @(negedge clock);
    chk($sformatf("%s ready", nm), 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; rd_val = rd;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      chk($sformatf("%s k%0d ctl", nm, k),
          32'({cs_n, ale, w_n, r_n, dbus_oe, cmd_ready, rsp_valid}), 32'(exp_ctl(k, wr)));
      chk($sformatf("%s k%0d abus", nm, k), 32'(abus), 32'(addr[15:8]));
      chk($sformatf("%s k%0d dbus_out", nm, k), 32'(dbus_out),
          32'((wr && k >= 5) ? wd : addr[7:0]));
      chk($sformatf("%s k%0d rdata", nm, k), 32'(rsp_rdata),
          32'((k >= 8) ? new_rd : exp_rdata));
      if (k == 1) cmd_valid = 1'b0;
      if (disturb) begin
        if (k == 2) begin cmd_addr = ~addr; cmd_wdata = ~wd; cmd_write = ~wr; end
        if (k == 3) cmd_valid = 1'b1;
        if (k == 4) cmd_valid = 1'b0;
      end
    end
    exp_rdata = new_rd;
    chk($sformatf("%s accepts", nm), 32'(accepts), 32'(ac0 + 1));
    chk($sformatf("%s latched addr", nm), 32'(lat_addr), 32'(addr));
    chk($sformatf("%s write count", nm), 32'(wr_log.size()), 32'(wc0 + (wr ? 1 : 0)));
    if (wr) chk($sformatf("%s write entry", nm), 32'(wr_log[wr_log.size() - 1]), 32'({addr, wd}));
  endtask

  initial begin
    int ac0, wc0, rc0, t1, t2, cs_high;
    bit got1, got2;

    // Reset with random inputs
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rd_val = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom); rd_val = 8'($urandom);
    end
    @(negedge clock);
    chk("reset ctl", 32'({cs_n, ale, w_n, r_n, dbus_oe, cmd_ready, rsp_valid}), 32'(7'b1011010));
    chk("reset abus", 32'(abus), 32'(0));
    chk("reset dbus_out", 32'(dbus_out), 32'(0));
    chk("reset rdata", 32'(rsp_rdata), 32'(0));
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clock);
    chk("ready after release", 32'(cmd_ready), 32'(1));

    run_txn("wr1234", 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0);
    run_txn("rd0042", 1'b0, 16'h0042, 8'h00, 8'h5C, 1'b0);
    run_txn("rdFF00", 1'b0, 16'hFF00, 8'h00, 8'hC3, 1'b0);

    // Back-to-back writes with cmd_valid held high
    ac0 = accepts; wc0 = wr_log.size();
    t1 = 0; t2 = 0; cs_high = 0; got1 = 0; got2 = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h2001; cmd_wdata = 8'h3C;
    for (int n = 1; n <= 40 && !got2; n++) begin
      @(negedge clock);
      if (got1 && accepts == ac0 + 2) begin
        got2 = 1; t2 = n; cmd_valid = 1'b0;
      end else if (accepts == ac0 + 1) begin
        if (!got1) begin
          got1 = 1; t1 = n; cmd_addr = 16'h2002; cmd_wdata = 8'hC4;
        end
        if (cs_n) cs_high++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b both accepted", 32'(got2), 32'(1));
    chk("b2b accept spacing", 32'(t2 - t1), 32'(11));
    chk("b2b cs_n high gap", 32'(cs_high), 32'(2));
    repeat (11) @(negedge clock);
    chk("b2b write count", 32'(wr_log.size()), 32'(wc0 + 2));
    chk("b2b first write", 32'(wr_log[wc0]), 32'({16'h2001, 8'h3C}));
    chk("b2b second write", 32'(wr_log[wc0 + 1]), 32'({16'h2002, 8'hC4}));
    exp_rdata = 8'h00;

    // Command inputs disturbed during a transaction
    run_txn("wr0300dist", 1'b1, 16'h0300, 8'h11, 8'h00, 1'b1);

    // Reset at k=6 of a write
    wc0 = wr_log.size(); rc0 = rsp_count;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h4321; cmd_wdata = 8'h99;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) cmd_valid = 1'b0;
    end
    @(posedge clock);
    #2;
    chk("pre-reset w_n", 32'(w_n), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("midreset ctl", 32'({cs_n, ale, w_n, r_n, dbus_oe, cmd_ready, rsp_valid}), 32'(7'b1011010));
    chk("midreset abus", 32'(abus), 32'(0));
    chk("midreset dbus_out", 32'(dbus_out), 32'(0));
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("midreset no rsp", 32'(rsp_count), 32'(rc0));
    chk("midreset no write", 32'(wr_log.size()), 32'(wc0));
    exp_rdata = 8'h00;
    run_txn("rd0077", 1'b0, 16'h0077, 8'h00, 8'hE1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
